// File: rtl/ram_latency_model.sv
`default_nettype none
// ============================================================================
// Module   : ram_latency_model
// Purpose  : Word-addressed main-memory model placed directly behind the
//            memory controller. Adds a fixed, configurable access latency,
//            reports a per-cycle FREE/BUSY/ACCESS/ERROR status and flags
//            illegal requests.
// Ports    : CLK       - clock, rising edge
//            nRST      - synchronous active-low reset
//            ramaddr   - byte address of the request
//            ramREN    - read request
//            ramWEN    - write request
//            ramstore  - write data
//            ramload   - read data, valid during the ACCESS cycle of a read
//            ramstate  - 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//            rd_cnt    - completed reads (wraps)
//            wr_cnt    - completed writes (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module ram_latency_model #(
    parameter int WORDS = 1024,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int IW = $clog2(WORDS);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    // With LAT == 0 the COUNT state is never entered, so this value is unused.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ACK   = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    cnt;
    logic [IW-1:0] q_addr;
    logic          q_wen;
    logic [31:0]   q_store;
    logic [31:0]   mem [WORDS];

    logic          req;
    logic          illegal;
    logic          changed;
    logic [IW-1:0] word_idx;
    logic [31:0]   q_addr_ext;

    logic          latch;
    logic          reload;
    logic          dec;
    logic          do_acc;
    logic [IW-1:0] acc_idx;
    logic          acc_wen;
    logic [31:0]   acc_data;

    assign req        = ramREN | ramWEN;
    assign illegal    = (ramREN & ramWEN)
                      | (ramaddr[1:0] != 2'b00)
                      | ((ramaddr >> (IW + 2)) != 32'd0);
    assign word_idx   = ramaddr[IW+1:2];
    assign q_addr_ext = 32'({q_addr, 2'b00});

    // A latched request is legal, so exactly one enable was set: a latched
    // read (q_wen = 0) expects REN = 1, a latched write expects REN = 0.
    // REN therefore differs from the latched request exactly when it
    // equals q_wen.
    assign changed = (ramaddr  != q_addr_ext)
                   | (ramWEN   != q_wen)
                   | (ramREN   == q_wen)
                   | (ramstore != q_store);

    always_comb begin
        next_state = state;
        latch      = 1'b0;
        reload     = 1'b0;
        dec        = 1'b0;
        do_acc     = 1'b0;
        acc_idx    = q_addr;
        acc_wen    = q_wen;
        acc_data   = q_store;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        next_state = ERR;
                    end else begin
                        latch = 1'b1;
                        if (LAT == 0) begin
                            // Zero latency: access straight from the inputs.
                            next_state = ACK;
                            do_acc     = 1'b1;
                            acc_idx    = word_idx;
                            acc_wen    = ramWEN;
                            acc_data   = ramstore;
                        end else begin
                            reload     = 1'b1;
                            next_state = COUNT;
                        end
                    end
                end
            end
            COUNT: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (changed) begin
                    // Controller switched initiator mid-access: start over.
                    if (illegal) begin
                        next_state = ERR;
                    end else begin
                        latch  = 1'b1;
                        reload = 1'b1;
                    end
                end else if (cnt == 4'd0) begin
                    next_state = ACK;
                    do_acc     = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            ERR: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            q_addr  <= '0;
            q_wen   <= 1'b0;
            q_store <= 32'd0;
            ramload <= 32'd0;
            rd_cnt  <= 32'd0;
            wr_cnt  <= 32'd0;
        end else begin
            state <= next_state;
            if (latch) begin
                q_addr  <= word_idx;
                q_wen   <= ramWEN;
                q_store <= ramstore;
            end
            if (reload) begin
                cnt <= CNT_LOAD;
            end else if (dec) begin
                cnt <= cnt - 4'd1;
            end
            if (do_acc && !acc_wen) begin
                ramload <= mem[acc_idx];
            end
            // Completion is counted on the edge that leaves ACK.
            if (state == ACK) begin
                if (q_wen) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    // Memory contents are not reset; a write in flight is dropped on reset.
    always_ff @(posedge CLK) begin
        if (nRST && do_acc && acc_wen) begin
            mem[acc_idx] <= acc_data;
        end
    end

    always_comb begin
        ramstate = FREE;
        unique case (state)
            IDLE:    ramstate = FREE;
            COUNT:   ramstate = BUSY;
            ACK:     ramstate = ACCESS;
            ERR:     ramstate = ERROR;
            default: ramstate = FREE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/ram_latency_model.md
# ram_latency_model

Word-addressed, synthesizable main-memory model that sits directly downstream of the memory controller. It consumes the controller's single RAM request (address, read/write enables, store data) and produces read data plus a per-cycle `ramstate_t` status. It models a configurable fixed access latency and flags illegal requests, so the controller's wait generation and its arbitration can be exercised cycle-accurately.

## Interface
- `WORDS`, 1024: memory depth in 32-bit words; must be a power of two ≥ 2; `IW = $clog2(WORDS)`.
- `LAT`, 2: BUSY cycles per access; legal range 0..15.

- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset; synchronous and active-low, sampled on the rising edge of `CLK`.
- `ramaddr`  in  32  byte address (`word_t`).
- `ramREN`  in  1  read request.
- `ramWEN`  in  1  write request.
- `ramstore`  in  32  write data.
- `ramload`  out  32  read data.
- `ramstate`  out  2  `ramstate_t`: FREE, BUSY, ACCESS or ERROR.
- `rd_cnt`  out  32  completed reads; wraps modulo 2^32.
- `wr_cnt`  out  32  completed writes; wraps modulo 2^32.

## Operation
- A request is present when `ramREN | ramWEN`.
- A request is illegal if any of the following hold:
  - `ramREN & ramWEN`
  - `ramaddr[1:0] != 0`
  - `ramaddr[31:IW+2] != 0`
- Word index = `ramaddr[IW+1:2]`.
- Latched request registers: `q_addr`, `q_wen`, `q_store`.
- Down-counter `cnt` is 4 bits wide.

FSM, with `ramstate` decoded from the state register only (no input-to-output path):
- IDLE (FREE):
  - No request: stay in IDLE.
  - Illegal request: go to ERR.
  - Legal request: latch it; if `LAT == 0` go to ACK, else load `cnt = LAT - 1` and go to COUNT.
- COUNT (BUSY):
  - Request dropped: go to IDLE. Nothing is written.
  - `ramaddr`, `ramREN`, `ramWEN` or `ramstore` differs from the latched value: restart. If the new request is illegal go to ERR; otherwise re-latch and reload `cnt = LAT - 1`. The restart handles the controller switching initiator mid-access.
  - Otherwise, if `cnt == 0`: go to ACK. On this same edge, a write stores `q_store` into `mem[q_addr]`; a read loads `ramload <= mem[q_addr]`.
  - Otherwise: `cnt` decrements.
- IDLE → ACK (when `LAT == 0`) performs the same write or load on that edge.
- ACK (ACCESS): lasts exactly one cycle and always goes to IDLE. Inputs are ignored in this cycle. `rd_cnt` or `wr_cnt` increments on the edge leaving ACK.
- ERR (ERROR): stays in ERR while any request is present. Goes to IDLE once `ramREN = ramWEN = 0`. Memory and the counters are untouched.
- `ramload` holds its value outside the edge that enters ACK on a read; writes never change it.
- Memory array contents are not reset.

## Timing
- On reset (`nRST` = 0 at an edge): state = IDLE, `ramstate` = FREE, `ramload` = 0, `rd_cnt` = `wr_cnt` = 0, `cnt` = 0, latched request registers = 0. This applies from any state, including mid-COUNT or in ACK; a write in flight is dropped.
- Steady request first seen in cycle t (state IDLE): FREE at t; BUSY for t+1..t+LAT; ACCESS at t+LAT+1; FREE at t+LAT+2. Read data is valid throughout the ACCESS cycle.
- A request held across ACCESS is treated as a new access starting at t+LAT+2, so back-to-back accesses to the same word repeat the full latency.
- Read-after-write is exact: a write whose ACCESS is at cycle a, followed by a read of the same word, returns the new data.
- A restart at BUSY cycle k delays ACCESS to k+LAT+1.

## Test plan
- LAT=2, reset, write `ramaddr=0x10`, `ramstore=0xDEADBEEF` held → ramstate FREE, BUSY, BUSY, ACCESS, FREE; `wr_cnt=1`. Then read 0x10 → ACCESS cycle shows `ramload=0xDEADBEEF`; `rd_cnt=1`.
- LAT=0, read 0x4 held for 6 cycles → pattern FREE, ACCESS, FREE, ACCESS, FREE, ACCESS; `rd_cnt` increments 3 times.
- LAT=3, read 0x20 then change `ramaddr` to 0x24 in the 2nd BUSY cycle → BUSY count restarts; the single ACCESS returns `mem[9]`; `rd_cnt` +1 only.
- Illegal requests: REN & WEN together, address 0x3, and address 0x1000 with WORDS=1024 → ERROR held while asserted; FREE one cycle after the request drops; memory and counters unchanged.
- Write 0x8 with LAT=4, deassert `nRST` in the 2nd BUSY cycle → next cycle FREE, `ramload=0`, counters 0; a read of 0x8 does not return the aborted data.
- Write dropped mid-COUNT (WEN → 0) → IDLE next edge; `mem` unchanged; `wr_cnt` unchanged.
